// File: rtl/hyperbus_burst_splitter.sv
// Splits linear read/write requests into HyperBus controller transactions bounded by
// MAX_BURST and chip-select boundaries. Optional register access: HYPERBUS_SPLIT_REG_EN.
module hyperbus_burst_splitter #(
  parameter int unsigned NR_CS        = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned MAX_BURST    = 256,
  parameter int unsigned CS_SIZE_LOG2 = 23
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_write_i,
  input  logic                           req_reg_i,
  input  logic [ADDR_W-1:0]              req_addr_i,
  input  logic [LEN_W-1:0]               req_len_i,
  output logic                           txn_valid_o,
  input  logic                           txn_ready_i,
  output logic [47:0]                    txn_ca_o,
  output logic [NR_CS-1:0]               txn_cs_o,
  output logic [$clog2(MAX_BURST+1)-1:0] txn_len_o,
  output logic                           txn_last_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int unsigned TLEN_W = $clog2(MAX_BURST + 1);
  localparam int unsigned CS_W   = (NR_CS > 1) ? $clog2(NR_CS) : 1;
  localparam int unsigned AW     = ADDR_W + 1;

  localparam logic [AW-1:0] ADDR_LIMIT  = AW'(NR_CS) << CS_SIZE_LOG2;
  localparam logic [AW-1:0] CS_BYTES    = AW'(1) << CS_SIZE_LOG2;
  localparam logic [AW-1:0] BURST_WORDS = AW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic                reg_q, reg_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [TLEN_W-1:0]   chunk_q, chunk_d;
  logic                zero_done_q, zero_done_d;

  logic                reg_eff;
  logic                req_bad;
  logic [AW-1:0]       chip_off;
  logic [AW-1:0]       words_left;
  logic [AW-1:0]       rem_ext;
  logic [AW-1:0]       chunk_calc;
  logic [AW-1:0]       addr_next;
  logic [LEN_W-1:0]    rem_next;
  logic                last;
  logic [31:0]         word_addr;
  logic [CS_W-1:0]     cs_idx;

`ifdef HYPERBUS_SPLIT_REG_EN
  assign reg_eff = req_reg_i;
`else
  logic reg_unused;
  assign reg_eff    = 1'b0;
  assign reg_unused = req_reg_i;
`endif

  // Register requests carry exactly one word, so the ordinary chunk computation
  // already yields a single one-word transaction once len==1 is enforced here.
  assign req_bad = req_addr_i[0]
                 | (AW'(req_addr_i) >= ADDR_LIMIT)
                 | (reg_eff & (req_len_i != LEN_W'(1)));

  always_comb begin
    chip_off   = AW'(addr_q[CS_SIZE_LOG2-1:0]);
    words_left = (CS_BYTES - chip_off) >> 1;
    rem_ext    = AW'(rem_q);
    chunk_calc = (rem_ext < BURST_WORDS) ? rem_ext : BURST_WORDS;
    if (words_left < chunk_calc) begin
      chunk_calc = words_left;
    end
  end

  assign addr_next = addr_q + (AW'(chunk_q) << 1);
  assign rem_next  = rem_q - LEN_W'(chunk_q);
  assign last      = (AW'(chunk_q) == rem_ext);
  assign word_addr = 32'(addr_q[CS_SIZE_LOG2-1:1]);
  assign cs_idx    = addr_q[CS_SIZE_LOG2 +: CS_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      reg_q       <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      chunk_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      chunk_q     <= chunk_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    reg_d       = reg_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    chunk_d     = chunk_q;
    zero_done_d = 1'b0;

    req_ready_o = 1'b0;
    txn_valid_o = 1'b0;
    txn_ca_o    = '0;
    txn_cs_o    = '0;
    txn_len_o   = '0;
    txn_last_o  = 1'b0;
    done_o      = zero_done_q;
    err_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          write_d = req_write_i;
          reg_d   = reg_eff;
          addr_d  = AW'(req_addr_i);
          rem_d   = req_len_i;
          if (req_bad) begin
            state_d = ERR;
          end else if (req_len_i == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        chunk_d = TLEN_W'(chunk_calc);
        state_d = EMIT;
      end
      EMIT: begin
        txn_valid_o = 1'b1;
        txn_ca_o    = {~write_q, reg_q, 1'b1, word_addr[31:3], 13'b0, word_addr[2:0]};
        txn_cs_o    = NR_CS'(1) << cs_idx;
        txn_len_o   = chunk_q;
        txn_last_o  = last;
        if (txn_ready_i) begin
          addr_d = addr_next;
          rem_d  = rem_next;
          if (last) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end else if (addr_next >= ADDR_LIMIT) begin
            state_d = ERR;
          end else begin
            state_d = CALC;
          end
        end
      end
      ERR: begin
        err_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Self-checking bench for hyperbus_burst_splitter: directed vector table, hand-written
// stall/reset sequences and randomized requests checked against a transaction-list model.
module tb_hyperbus_burst_splitter;

  localparam longint CHIP   = 64'h80_0000;
  localparam longint LIMIT  = 2 * CHIP;
  localparam int     BUDGET = 3000;
`ifdef HYPERBUS_SPLIT_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic        req_reg_i;
  logic [31:0] req_addr_i;
  logic [15:0] req_len_i;
  logic        txn_valid_o;
  logic        txn_ready_i;
  logic [47:0] txn_ca_o;
  logic [1:0]  txn_cs_o;
  logic [8:0]  txn_len_o;
  logic        txn_last_o;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hyperbus_burst_splitter #(
    .NR_CS(2), .ADDR_W(32), .LEN_W(16), .MAX_BURST(256), .CS_SIZE_LOG2(23)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_reg_i(req_reg_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .txn_valid_o(txn_valid_o), .txn_ready_i(txn_ready_i),
    .txn_ca_o(txn_ca_o), .txn_cs_o(txn_cs_o), .txn_len_o(txn_len_o),
    .txn_last_o(txn_last_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [47:0] ca;
    logic [1:0]  cs;
    int          len;
    logic        last;
  } txn_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] len;
    int          n_txn;
    logic [47:0] ca;
    logic [1:0]  cs;
    int          tlen;
    int          end_k;
  } vec_t;

  txn_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Expected transaction list built straight from the splitting rules.
  task automatic model(input logic wr, input logic rg, input logic [31:0] addr,
                       input logic [15:0] len, output int e_done, output int e_err);
    longint a, r, chunk, left, w;
    txn_t   t;
    bit     rg_eff;
    exp_q.delete();
    e_done = 0;
    e_err  = 0;
    rg_eff = REG_EN && rg;
    a = longint'(addr);
    r = longint'(len);
    if ((a % 2) != 0 || a >= LIMIT || (rg_eff && r != 1)) begin
      e_err = 1;
      return;
    end
    while (r > 0) begin
      if (a >= LIMIT) begin
        e_err = 1;
        return;
      end
      left  = (CHIP - (a % CHIP)) / 2;
      chunk = r;
      if (chunk > 256)  chunk = 256;
      if (chunk > left) chunk = left;
      w = (a % CHIP) / 2;
      t.ca   = 48'((longint'(!wr) << 47) + (longint'(rg_eff) << 46) + (64'd1 << 45)
                   + ((w / 8) << 16) + (w % 8));
      t.cs   = 2'(1 << (a / CHIP));
      t.len  = int'(chunk);
      t.last = (chunk == r);
      exp_q.push_back(t);
      a += 2 * chunk;
      r -= chunk;
    end
    e_done = 1;
  endtask

  task automatic run_req(input logic wr, input logic rg, input logic [31:0] addr,
                         input logic [15:0] len, input int stall_pct,
                         output int n_txn, output int first_k, output int end_k,
                         output logic [47:0] first_ca, output logic [1:0] first_cs,
                         output int first_len);
    int  e_done, e_err, n_done, n_err;
    bit  finished;
    model(wr, rg, addr, len, e_done, e_err);
    n_txn = 0; first_k = -1; end_k = -1; first_ca = '0; first_cs = '0; first_len = 0;
    n_done = 0; n_err = 0; finished = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_write_i = wr; req_reg_i = rg;
    req_addr_i = addr; req_len_i = len; txn_ready_i = 1'b0;
    #1;
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      txn_ready_i = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (txn_valid_o) begin
        if (first_k < 0) begin
          first_k = k; first_ca = txn_ca_o; first_cs = txn_cs_o; first_len = int'(txn_len_o);
        end
        if (exp_q.size() == 0) begin
          chk("txn_unexpected", 64'(txn_valid_o), 64'd0);
        end else begin
          chk("txn_ca", 64'(txn_ca_o), 64'(exp_q[0].ca));
          chk("txn_cs", 64'(txn_cs_o), 64'(exp_q[0].cs));
          chk("txn_len", 64'(txn_len_o), 64'(exp_q[0].len));
          chk("txn_last", 64'(txn_last_o), 64'(exp_q[0].last));
          if (txn_ready_i) begin
            chk("done_with_last", 64'(done_o), 64'(exp_q[0].last));
            void'(exp_q.pop_front());
            n_txn++;
          end
        end
      end
      if (done_o) n_done++;
      if (err_o)  n_err++;
      if (req_ready_o) begin
        finished = 1;
        end_k = k;
        break;
      end
      @(negedge clk);
    end
    txn_ready_i = 1'b0;
    chk("req_timeout", 64'(finished), 64'd1);
    chk("done_count", 64'(n_done), 64'(e_done));
    chk("err_count", 64'(n_err), 64'(e_err));
    chk("txn_remaining", 64'(exp_q.size()), 64'd0);
    chk("idle_txn_valid", 64'(txn_valid_o), 64'd0);
  endtask

  vec_t        vecs[8];
  int          n_txn, first_k, end_k, first_len;
  logic [47:0] first_ca, cap_ca;
  logic [1:0]  first_cs;
  logic [63:0] snap;
  logic [31:0] ra;
  logic [15:0] rl;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 16'd4,   1, 48'hA000_0010_0000, 2'b01, 4,   3};
    vecs[1] = '{1'b1, 32'h0000_0000, 16'd600, 3, 48'h2000_0000_0000, 2'b01, 256, 7};
    vecs[2] = '{1'b0, 32'h007F_FFFC, 16'd4,   2, 48'hA007_FFFF_0006, 2'b01, 2,   5};
    vecs[3] = '{1'b0, 32'h0000_0101, 16'd4,   0, 48'h0,              2'b00, 0,   2};
    vecs[4] = '{1'b0, 32'h0100_0000, 16'd1,   0, 48'h0,              2'b00, 0,   2};
    vecs[5] = '{1'b0, 32'h0000_0010, 16'd0,   0, 48'h0,              2'b00, 0,   1};
    vecs[6] = '{1'b0, 32'h00FF_FFFC, 16'd4,   1, 48'hA007_FFFF_0006, 2'b10, 2,   4};
    vecs[7] = '{1'b1, 32'h0080_0000, 16'd1,   1, 48'h2000_0000_0000, 2'b10, 1,   3};

    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_reg_i = 1'b0;
    req_addr_i = '0; req_len_i = '0; txn_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_outputs", {txn_ca_o, txn_cs_o, txn_len_o, txn_valid_o, txn_last_o, done_o, err_o},
        64'd0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].len, 0,
              n_txn, first_k, end_k, first_ca, first_cs, first_len);
      chk($sformatf("vec%0d_n_txn", i), 64'(n_txn), 64'(vecs[i].n_txn));
      chk($sformatf("vec%0d_end_k", i), 64'(end_k), 64'(vecs[i].end_k));
      if (vecs[i].n_txn > 0) begin
        chk($sformatf("vec%0d_first_k", i), 64'(first_k), 64'd2);
        chk($sformatf("vec%0d_ca", i), 64'(first_ca), 64'(vecs[i].ca));
        chk($sformatf("vec%0d_cs", i), 64'(first_cs), 64'(vecs[i].cs));
        chk($sformatf("vec%0d_len", i), 64'(first_len), 64'(vecs[i].tlen));
      end
    end

    // Stall in EMIT for five cycles, then reset mid-request.
    @(negedge clk);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_reg_i = 1'b0;
    req_addr_i = 32'h0000_0040; req_len_i = 16'd20; txn_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    for (int k = 0; k < 10 && !txn_valid_o; k++) begin
      @(negedge clk);
      #1;
    end
    chk("stall_reach_emit", 64'(txn_valid_o), 64'd1);
    cap_ca = txn_ca_o;
    chk("stall_ca", 64'(cap_ca), 64'hA000_0004_0000);
    snap = {3'b0, txn_ca_o, txn_cs_o, txn_len_o, txn_last_o, txn_valid_o};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stall_stable", {3'b0, txn_ca_o, txn_cs_o, txn_len_o, txn_last_o, txn_valid_o}, snap);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("midrst_txn_valid", 64'(txn_valid_o), 64'd0);
    chk("midrst_req_ready", 64'(req_ready_o), 64'd1);
    chk("midrst_pulses", 64'({done_o, err_o}), 64'd0);

`ifdef HYPERBUS_SPLIT_REG_EN
    run_req(1'b0, 1'b1, 32'h0000_0002, 16'd1, 0, n_txn, first_k, end_k, first_ca, first_cs,
            first_len);
    chk("reg_ca", 64'(first_ca), 64'hE000_0000_0001);
    chk("reg_len", 64'(first_len), 64'd1);
    run_req(1'b0, 1'b1, 32'h0000_0002, 16'd2, 0, n_txn, first_k, end_k, first_ca, first_cs,
            first_len);
    chk("reg_badlen_n_txn", 64'(n_txn), 64'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: ra = $urandom & 32'h00FF_FFFE;
        1: ra = 32'h0080_0000 - 2 * $urandom_range(0, 300);
        2: ra = 32'h0100_0000 - 2 * $urandom_range(1, 300);
        3: ra = $urandom;
        default: ra = ($urandom & 32'h00FF_FFFF) | 32'd1;
      endcase
      rl = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 700));
      run_req(1'($urandom), 1'($urandom), ra, rl, 30, n_txn, first_k, end_k, first_ca,
              first_cs, first_len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
